io_port: RTL and testbench

Addressed I/O responder for the CPU's RD/WR/SIG bus, the far end of the control decoder's I/O strobes. It sits between the CPU datapath and one external byte-stream device. Inbound bytes are buffered in a small FIFO that the CPU drains with RD. Outbound bytes written with WR are held in a register and handed off over a valid/ready handshake. A status register lets software poll buffer state and a sticky overrun flag.

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_fifo.sv | 55 +++++
 rtl/io_port.sv | 114 +++++++++++
 tb/tb_io_port.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the addressed I/O port: register select codes,
// status bit layout and default inbound buffer depth.
package io_pkg;

    localparam logic IO_REG_DATA   = 1'b0;
    localparam logic IO_REG_STATUS = 1'b1;

    localparam int unsigned ST_RXNE   = 0;
    localparam int unsigned ST_TXBUSY = 1;
    localparam int unsigned ST_CNT_LO = 2;
    localparam int unsigned ST_CNT_HI = 4;
    localparam int unsigned ST_OVR    = 5;

    localparam int unsigned IO_DEPTH_DEFAULT = 4;

    // Occupancy as reported in the 3-bit status count field.
    function automatic logic [2:0] sat3(input int unsigned n);
        return (n > 7) ? 3'd7 : n[2:0];
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Byte-wide inbound FIFO; the caller only pushes when not full and only pops
// when not empty.
module io_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [7:0]      wdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count,
    output logic [7:0]      head
);

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;

    // Storage needs no reset: reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/io_port.sv
// Addressed I/O responder: inbound byte FIFO drained by RD, outbound holding
// register loaded by WR with a valid/ready handoff, and a polled status register.
module io_port
    import io_pkg::*;
#(
    parameter logic [6:0]  ADDR  = 7'h00,
    parameter int unsigned DEPTH = IO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] sig,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            sel, data_rd, status_rd, data_wr;
    logic            push, pop, full, empty;
    logic [CntW-1:0] count;
    logic [7:0]      head;
    logic [7:0]      status;
    logic            load, drop;

    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       ovr_q, ovr_d;

    assign sel       = (sig[7:1] == ADDR);
    assign data_rd   = rd & sel & (sig[0] == IO_REG_DATA);
    assign status_rd = rd & sel & (sig[0] == IO_REG_STATUS);
    assign data_wr   = wr & sel & (sig[0] == IO_REG_DATA);

    // Held low in reset so the device never sees a push that gets discarded.
    assign in_ready = rst_n & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = data_rd & ~empty;

    io_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // A slot is free if empty now or being drained at this same edge.
    assign load = data_wr & (~out_valid_q | out_ready);
    assign drop = data_wr & out_valid_q & ~out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovr_d       = ovr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = wdata;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (status_rd) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            ovr_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        status                       = 8'h00;
        status[ST_RXNE]              = ~empty;
        status[ST_TXBUSY]            = out_valid_q;
        status[ST_CNT_HI:ST_CNT_LO]  = sat3(int'(count));
        status[ST_OVR]               = ovr_q;
    end

    always_comb begin
        rdata = 8'h00;
        if (status_rd) begin
            rdata = status;
        end else if (data_rd && !empty) begin
            rdata = head;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based reference model.
module tb_io_port;

    localparam int unsigned DEPTH = 4;
    localparam logic [6:0]  ADDR  = 7'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd = 1'b0, wr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] sig = 8'h00, wdata = 8'h00, in_data = 8'h00;
    logic [7:0] rdata, out_data;
    logic       in_ready, out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] mq[$];
    logic       m_ov  = 1'b0;
    logic [7:0] m_od  = 8'h00;
    logic       m_ovr = 1'b0;

    io_port #(
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .wr        (wr),
        .sig       (sig),
        .wdata     (wdata),
        .rdata     (rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] exp_rdata();
        int unsigned n;
        logic [2:0]  c;
        n = mq.size();
        c = (n > 7) ? 3'd7 : 3'(n);
        if (!rd || sig[7:1] != ADDR) return 8'h00;
        if (sig[0]) return {2'b00, m_ovr, c, m_ov, n != 0};
        return (n != 0) ? mq[0] : 8'h00;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check8("m_rdata", rdata, exp_rdata());
        check8("m_in_ready", {7'b0, in_ready}, {7'b0, rst_n && (mq.size() < DEPTH)});
        check8("m_out_valid", {7'b0, out_valid}, {7'b0, m_ov});
        check8("m_out_data", out_data, m_od);
    end

    always @(negedge rst_n) begin
        mq.delete();
        m_ov  = 1'b0;
        m_od  = 8'h00;
        m_ovr = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic sel, do_pop, do_push, dwr;
            sel     = (sig[7:1] == ADDR);
            do_pop  = rd && sel && !sig[0] && (mq.size() != 0);
            do_push = in_valid && (mq.size() < DEPTH);
            dwr     = wr && sel && !sig[0];
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
            if (dwr && m_ov && !out_ready) m_ovr = 1'b1;
            else if (rd && sel && sig[0]) m_ovr = 1'b0;
            if (dwr && (!m_ov || out_ready)) begin
                m_ov = 1'b1;
                m_od = wdata;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd = 1'b0;
        wr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic lit_status(input string name, input logic [7:0] req);
        rd  = 1'b1;
        sig = {ADDR, 1'b1};
        #1;
        check8(name, rdata, req);
    endtask

    initial begin
        logic [7:0] pat [4];
        // Reset state.
        #2;
        rd = 1'b1;
        sig = {ADDR, 1'b1};
        #1;
        check8("rst_in_ready", {7'b0, in_ready}, 8'h00);
        check8("rst_out_valid", {7'b0, out_valid}, 8'h00);
        check8("rst_out_data", out_data, 8'h00);
        check8("rst_rdata", rdata, 8'h00);
        rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check8("idle_in_ready", {7'b0, in_ready}, 8'h01);
        lit_status("idle_status", 8'h00);
        tick();
        idle();

        // Fill FIFO then drain in order.
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pat[i];
            tick();
        end
        idle();
        #1;
        check8("full_in_ready", {7'b0, in_ready}, 8'h00);
        lit_status("full_status", 8'h11);
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1;
            sig = {ADDR, 1'b0};
            #1;
            check8("drain_data", rdata, pat[i]);
            tick();
        end
        rd = 1'b1;
        sig = {ADDR, 1'b0};
        #1;
        check8("empty_read", rdata, 8'h00);
        tick();
        idle();

        // Full FIFO with simultaneous read and held in_valid.
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pat[i];
            tick();
        end
        in_data = 8'h55;
        rd = 1'b1;
        sig = {ADDR, 1'b0};
        #1;
        check8("fullrd_in_ready", {7'b0, in_ready}, 8'h00);
        check8("fullrd_data", rdata, 8'h11);
        tick();
        rd = 1'b0;
        #1;
        check8("freed_in_ready", {7'b0, in_ready}, 8'h01);
        tick();
        idle();
        lit_status("refill_status", 8'h11);
        pat[0] = 8'h22; pat[1] = 8'h33; pat[2] = 8'h44; pat[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1;
            sig = {ADDR, 1'b0};
            #1;
            check8("order_data", rdata, pat[i]);
            tick();
        end
        idle();

        // Outbound holding register and overrun.
        out_ready = 1'b0;
        wr = 1'b1; sig = {ADDR, 1'b0}; wdata = 8'h5A;
        tick();
        wdata = 8'h66;
        tick();
        idle();
        #1;
        check8("hold_valid", {7'b0, out_valid}, 8'h01);
        check8("hold_data", out_data, 8'h5A);
        lit_status("ovr_status", 8'h22);
        tick();
        lit_status("ovr_cleared", 8'h02);
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        #1;
        check8("drain_valid", {7'b0, out_valid}, 8'h00);

        // Back-to-back writes with out_ready held.
        for (int i = 1; i <= 3; i++) begin
            wr = 1'b1; sig = {ADDR, 1'b0}; wdata = 8'(i);
            tick();
            #1;
            check8("b2b_data", out_data, 8'(i));
            check8("b2b_valid", {7'b0, out_valid}, 8'h01);
        end
        idle();
        tick();
        lit_status("b2b_status", 8'h00);
        tick();
        idle();

        // Wrong address must not touch state.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        wr = 1'b1; sig = {ADDR, 1'b0}; wdata = 8'h88;
        tick();
        idle();
        rd = 1'b1; wr = 1'b1; sig = {ADDR + 7'd2, 1'b0}; wdata = 8'h99;
        #1;
        check8("badaddr_rdata", rdata, 8'h00);
        tick();
        wr = 1'b0;
        lit_status("badaddr_status", 8'h07);
        check8("badaddr_out", out_data, 8'h88);
        tick();
        idle();

        // Asynchronous reset mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        check8("arst_in_ready", {7'b0, in_ready}, 8'h00);
        check8("arst_out_valid", {7'b0, out_valid}, 8'h00);
        check8("arst_out_data", out_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rd        = ($urandom_range(0, 2) == 0);
            wr        = ($urandom_range(0, 2) == 0);
            in_valid  = ($urandom_range(0, 1) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            wdata     = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    sig = {ADDR, 1'b0};
                2, 3:    sig = {ADDR, 1'b1};
                default: sig = 8'($urandom);
            endcase
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
